// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with one 2-bit saturating counter per entry.
// The lookup is combinational on PC_F. Execute-stage outcomes train the table on the clock edge.
module branch_predictor #(
   parameter int ENTRIES = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] PC_F,
   output logic        Predict_Taken_F,
   output logic [31:0] Predict_Target_F,
   input  logic        Branch_E,
   input  logic [31:0] PC_E,
   input  logic        Branch_Taken_E,
   input  logic [31:0] Branch_Target_E
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [29:0]      target_q [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];

   logic [IDX_W-1:0] idxF, idxE;
   logic [TAG_W-1:0] tagF, tagE;
   logic             hitF, hitE;
   logic             ctrWe, tgtWe;
   logic [1:0]       ctr_d;
   logic             unusedBits;

   assign idxF = PC_F[IDX_W+1:2];
   assign tagF = PC_F[31:IDX_W+2];
   assign idxE = PC_E[IDX_W+1:2];
   assign tagE = PC_E[31:IDX_W+2];
   assign unusedBits = ^{PC_F[1:0], PC_E[1:0], Branch_Target_E[1:0]};

   // Lookup reads the pre-update table, so same-cycle training shows up one cycle later
   always_comb begin
      hitF             = valid_q[idxF] && (tag_q[idxF] == tagF);
      Predict_Taken_F  = hitF && ctr_q[idxF][1];
      Predict_Target_F = hitF ? {target_q[idxF], 2'b00} : 32'h0;
   end

   always_comb begin
      hitE  = valid_q[idxE] && (tag_q[idxE] == tagE);
      ctrWe = Branch_E && (hitE || Branch_Taken_E);
      tgtWe = Branch_E && Branch_Taken_E;
      ctr_d = ctr_q[idxE];
      if (!hitE) begin
         ctr_d = 2'b10;
      end else if (Branch_Taken_E) begin
         if (ctr_q[idxE] != 2'b11) ctr_d = ctr_q[idxE] + 2'b01;
      end else begin
         if (ctr_q[idxE] != 2'b00) ctr_d = ctr_q[idxE] - 2'b01;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b01;
         end
      end else if (ctrWe) begin
         valid_q[idxE] <= 1'b1;
         ctr_q[idxE]   <= ctr_d;
      end
   end

   // Tag and target need no reset; they are ignored while valid is low
   always_ff @(posedge CLK) begin
      if (!RST && tgtWe) begin
         tag_q[idxE]    <= tagE;
         target_q[idxE] <= Branch_Target_E[31:2];
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: an associative model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_branch_predictor;

   localparam int ENTRIES = 16;

   logic        CLK;
   logic        RST;
   logic [31:0] PC_F;
   logic        Predict_Taken_F;
   logic [31:0] Predict_Target_F;
   logic        Branch_E;
   logic [31:0] PC_E;
   logic        Branch_Taken_E;
   logic [31:0] Branch_Target_E;

   int checks   = 0;
   int failures = 0;
   bit modelOn  = 0;

   // Model entry: the full word address of the owning branch, its target and its counter value
   bit          mValid  [ENTRIES];
   logic [29:0] mWord   [ENTRIES];
   logic [31:0] mTarget [ENTRIES];
   int          mCtr    [ENTRIES];

   branch_predictor #(.ENTRIES(ENTRIES)) dut (
      .CLK(CLK),
      .RST(RST),
      .PC_F(PC_F),
      .Predict_Taken_F(Predict_Taken_F),
      .Predict_Target_F(Predict_Target_F),
      .Branch_E(Branch_E),
      .PC_E(PC_E),
      .Branch_Taken_E(Branch_Taken_E),
      .Branch_Target_E(Branch_Target_E)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Model training follows the same edge as the DUT, using the inputs held across it
   always @(posedge CLK) begin
      int i;
      if (RST) begin
         for (int k = 0; k < ENTRIES; k++) begin
            mValid[k] = 1'b0;
            mCtr[k]   = 1;
         end
      end else if (Branch_E) begin
         i = int'(PC_E[31:2]) % ENTRIES;
         if (mValid[i] && mWord[i] == PC_E[31:2]) begin
            if (Branch_Taken_E) begin
               mCtr[i]    = (mCtr[i] < 3) ? mCtr[i] + 1 : 3;
               mTarget[i] = {Branch_Target_E[31:2], 2'b00};
            end else begin
               mCtr[i] = (mCtr[i] > 0) ? mCtr[i] - 1 : 0;
            end
         end else if (Branch_Taken_E) begin
            mValid[i]  = 1'b1;
            mWord[i]   = PC_E[31:2];
            mTarget[i] = {Branch_Target_E[31:2], 2'b00};
            mCtr[i]    = 2;
         end
      end
   end

   always @(negedge CLK) begin
      int i;
      bit hit;
      logic        expTaken;
      logic [31:0] expTarget;
      if (modelOn) begin
         i         = int'(PC_F[31:2]) % ENTRIES;
         hit       = mValid[i] && mWord[i] == PC_F[31:2];
         expTaken  = hit && mCtr[i] >= 2;
         expTarget = hit ? mTarget[i] : 32'h0;
         checks++;
         if (Predict_Taken_F !== expTaken || Predict_Target_F !== expTarget) begin
            failures++;
            $display("[TB] FAIL model pc=%h: got taken=%0b target=%h, expected taken=%0b target=%h",
                     PC_F, Predict_Taken_F, Predict_Target_F, expTaken, expTarget);
         end
      end
   end

   task automatic applyStimulus(input logic rst, input logic [31:0] pcF, input logic be,
                                input logic [31:0] pcE, input logic tk, input logic [31:0] tgt);
      RST             = rst;
      PC_F            = pcF;
      Branch_E        = be;
      PC_E            = pcE;
      Branch_Taken_E  = tk;
      Branch_Target_E = tgt;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic expTaken, input logic [31:0] expTarget);
      @(negedge CLK);
      checks++;
      if (Predict_Taken_F !== expTaken || Predict_Target_F !== expTarget) begin
         failures++;
         $display("[TB] FAIL %s: got taken=%0b target=%h, expected taken=%0b target=%h",
                  name, Predict_Taken_F, Predict_Target_F, expTaken, expTarget);
      end
   endtask

   task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      applyStimulus(1'b0, 32'h0, 1'b1, pc, tk, tgt);
      tick();
   endtask

   task automatic lookup(input string name, input logic [31:0] pc, input logic expTaken,
                         input logic [31:0] expTarget);
      applyStimulus(1'b0, pc, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput(name, expTaken, expTarget);
      tick();
   endtask

   initial begin
      applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      modelOn = 1;

      lookup("T1 reset", 32'h100, 1'b0, 32'h0);

      applyStimulus(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200);
      checkOutput("T2 before alloc", 1'b0, 32'h0);
      tick();
      lookup("T2 alloc", 32'h100, 1'b1, 32'h200);

      train(32'h100, 1'b0, 32'h0);
      lookup("T3 weakNT", 32'h100, 1'b0, 32'h200);
      train(32'h100, 1'b1, 32'h200);
      train(32'h100, 1'b1, 32'h200);
      train(32'h100, 1'b1, 32'h200);
      lookup("T3 strongT", 32'h100, 1'b1, 32'h200);
      train(32'h100, 1'b0, 32'h0);
      lookup("T3 saturated", 32'h100, 1'b1, 32'h200);
      train(32'h100, 1'b0, 32'h0);
      lookup("T3 down2", 32'h100, 1'b0, 32'h200);

      train(32'h100, 1'b1, 32'h200);
      lookup("T4 retrain", 32'h100, 1'b1, 32'h200);
      lookup("T4 alias miss", 32'h140, 1'b0, 32'h0);
      train(32'h140, 1'b1, 32'h300);
      lookup("T4 evicted", 32'h100, 1'b0, 32'h0);
      lookup("T4 new owner", 32'h140, 1'b1, 32'h300);

      train(32'h180, 1'b0, 32'h0);
      lookup("T5 no alloc", 32'h180, 1'b0, 32'h0);
      lookup("T5 owner kept", 32'h140, 1'b1, 32'h300);
      for (int n = 0; n < 8; n++) begin
         applyStimulus(1'b0, (n % 2 == 0) ? 32'h140 : 32'h180, 1'b0,
                       (n % 2 == 0) ? 32'h140 : $urandom, 1'($urandom), $urandom);
         tick();
      end
      lookup("T5 idle", 32'h140, 1'b1, 32'h300);

      train(32'h100, 1'b1, 32'h200);
      train(32'h104, 1'b1, 32'h500);
      lookup("T6 second idx", 32'h104, 1'b1, 32'h500);
      applyStimulus(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0);
      checkOutput("T6 same cycle old", 1'b1, 32'h200);
      tick();
      lookup("T6 next cycle new", 32'h100, 1'b0, 32'h200);
      applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h400);
      tick();
      lookup("T6 reset 0x100", 32'h100, 1'b0, 32'h0);
      lookup("T6 reset 0x104", 32'h104, 1'b0, 32'h0);
      lookup("T6 reset 0x140", 32'h140, 1'b0, 32'h0);

      modelOn = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
